// File: rtl/uart_cmd_parser.sv
// Streaming UART command parser: "SW:"/"BT:" + spaces + "0x" + hex digits + CR/LF drives switch/button vectors.
// Optional idle-gap abort is compiled in with `define CMD_TIMEOUT_EN (limit TIMEOUT_CYCLES clk cycles).
//
// state     | meaning
// IDLE      | waiting for 'S' or 'B'; target latched here
// PFX2      | expecting 'W' (switch) or 'T' (button)
// COLON     | expecting ':'
// SPACE     | skipping spaces, expecting '0'
// ZERO_X    | expecting 'x' or 'X'
// HEX_FIRST | expecting the first hex digit
// HEX_MORE  | more hex digits, or CR/LF to apply
module uart_cmd_parser #(
  parameter int SWITCH_COUNT   = 16,
  parameter int BUTTON_COUNT   = 5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ena,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [SWITCH_COUNT-1:0] switch_data,
  output logic [BUTTON_COUNT-1:0] button_data,
  output logic                    cmd_done,
  output logic                    cmd_error
);

  localparam int MAX_W      = (SWITCH_COUNT > BUTTON_COUNT) ? SWITCH_COUNT : BUTTON_COUNT;
  localparam int MAX_DIGITS = (MAX_W + 3) / 4;
  localparam int ACC_W      = 4 * MAX_DIGITS;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PFX2      = 3'd1;
  localparam logic [2:0] ST_COLON     = 3'd2;
  localparam logic [2:0] ST_SPACE     = 3'd3;
  localparam logic [2:0] ST_ZERO_X    = 3'd4;
  localparam logic [2:0] ST_HEX_FIRST = 3'd5;
  localparam logic [2:0] ST_HEX_MORE  = 3'd6;

  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_W     = 8'h57;
  localparam logic [7:0] CH_B     = 8'h42;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_X_UP  = 8'h58;
  localparam logic [7:0] CH_X_LO  = 8'h78;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  logic [2:0]       state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, is_hex, is_term, apply, abort, timeout_hit;
  logic [3:0]       nibble;

  assign accept  = ena & rx_valid;
  assign is_term = (rx_data == CH_CR) || (rx_data == CH_LF);
  assign is_hex  = ((rx_data >= 8'h30) && (rx_data <= 8'h39)) ||
                   ((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
                   ((rx_data >= 8'h61) && (rx_data <= 8'h66));
  // Letters A-F / a-f share low nibble 1..6, so add 9 to reach 10..15.
  assign nibble  = (rx_data <= 8'h39) ? rx_data[3:0] : (rx_data[3:0] + 4'd9);

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q;

  assign timeout_hit = ena && !rx_valid && (state_q != ST_IDLE) &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (ena) begin
      if (rx_valid || (state_q == ST_IDLE) || timeout_hit) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    apply   = 1'b0;
    abort   = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == CH_S) begin
            state_d = ST_PFX2;
            tgt_d   = 1'b0;
          end else if (rx_data == CH_B) begin
            state_d = ST_PFX2;
            tgt_d   = 1'b1;
          end
        end
        ST_PFX2: begin
          if ((!tgt_q && rx_data == CH_W) || (tgt_q && rx_data == CH_T)) state_d = ST_COLON;
          else abort = 1'b1;
        end
        ST_COLON: begin
          if (rx_data == CH_COLON) state_d = ST_SPACE;
          else abort = 1'b1;
        end
        ST_SPACE: begin
          if (rx_data == CH_ZERO) state_d = ST_ZERO_X;
          else if (rx_data != CH_SPACE) abort = 1'b1;
        end
        ST_ZERO_X: begin
          if ((rx_data == CH_X_UP) || (rx_data == CH_X_LO)) begin
            state_d = ST_HEX_FIRST;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            abort = 1'b1;
          end
        end
        ST_HEX_FIRST: begin
          if (is_hex) begin
            state_d = ST_HEX_MORE;
            acc_d   = (acc_q << 4) | ACC_W'(nibble);
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            abort = 1'b1;
          end
        end
        ST_HEX_MORE: begin
          if (is_hex && (cnt_q < CNT_W'(MAX_DIGITS))) begin
            acc_d = (acc_q << 4) | ACC_W'(nibble);
            cnt_d = cnt_q + CNT_W'(1);
          end else if (is_term) begin
            apply   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            abort = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      abort = 1'b1;
    end
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      switch_data <= '0;
      button_data <= '0;
      cmd_done    <= 1'b0;
      cmd_error   <= 1'b0;
    end else if (ena) begin
      cmd_done  <= apply;
      cmd_error <= abort;
      if (apply) begin
        if (tgt_q) button_data <= acc_q[BUTTON_COUNT-1:0];
        else       switch_data <= acc_q[SWITCH_COUNT-1:0];
      end
    end else begin
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a string-level grammar model predicts each done/error pulse.
module tb_uart_cmd_parser;
  localparam int SWC  = 16;
  localparam int BTC  = 5;
  localparam int TOC  = 16;
  localparam int MAXD = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           ena = 1'b1;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_valid = 1'b0;
  logic [SWC-1:0] switch_data;
  logic [BTC-1:0] button_data;
  logic           cmd_done, cmd_error;

  always #5 clk = ~clk;

  uart_cmd_parser #(.SWITCH_COUNT(SWC), .BUTTON_COUNT(BTC), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .rx_data(rx_data), .rx_valid(rx_valid),
    .switch_data(switch_data), .button_data(button_data),
    .cmd_done(cmd_done), .cmd_error(cmd_error)
  );

  typedef struct {
    bit          is_err;
    logic [15:0] sw;
    logic [4:0]  bt;
    int          when;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_x;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           neg_cnt = 0;
  bit           in_cmd = 0;
  byte unsigned cbuf[$];
  logic [15:0]  m_sw = '0;
  logic [4:0]   m_bt = '0;
  int           stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input bit e);
    exp_t x;
    x.is_err = e;
    x.sw     = m_sw;
    x.bt     = m_bt;
    x.when   = neg_cnt + 1;
    exp_q.push_back(x);
  endtask

  function automatic bit hexc(input byte unsigned c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int hexv(input byte unsigned c);
    if (c <= "9") return int'(c) - 48;
    if (c <= "F") return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  // 0 = valid so far, 1 = complete command, 2 = violates the grammar
  function automatic int parse(input byte unsigned b[$], output int val);
    int n, i, nd;
    byte unsigned need;
    val  = 0;
    n    = b.size();
    need = (b[0] == "S") ? "W" : "T";
    if (n < 2) return 0;
    if (b[1] != need) return 2;
    if (n < 3) return 0;
    if (b[2] != ":") return 2;
    i = 3;
    while (i < n && b[i] == " ") i++;
    if (i == n) return 0;
    if (b[i] != "0") return 2;
    i++;
    if (i == n) return 0;
    if (b[i] != "x" && b[i] != "X") return 2;
    i++;
    nd = 0;
    while (i < n && hexc(b[i])) begin
      if (nd == MAXD) return 2;
      val = val * 16 + hexv(b[i]);
      nd++;
      i++;
    end
    if (i == n) return 0;
    if ((b[i] == 8'h0D || b[i] == 8'h0A) && nd >= 1) return 1;
    return 2;
  endfunction

  task automatic model_accept(input byte unsigned b);
    int r, v;
    stall = 0;
    if (!in_cmd) begin
      if (b == "S" || b == "B") begin
        in_cmd = 1;
        cbuf.delete();
        cbuf.push_back(b);
      end
    end else begin
      cbuf.push_back(b);
      r = parse(cbuf, v);
      if (r == 2) begin
        in_cmd = 0;
        push(1'b1);
      end else if (r == 1) begin
        in_cmd = 0;
        if (cbuf[0] == "S") m_sw = v[15:0];
        else m_bt = v[4:0];
        push(1'b0);
      end
    end
  endtask

  task automatic model_edge(input bit valid, input byte unsigned b);
    if (!ena) return;
    if (valid) begin
      model_accept(b);
    end else begin
`ifdef CMD_TIMEOUT_EN
      if (in_cmd) begin
        if (stall == TOC - 1) begin
          in_cmd = 0;
          stall  = 0;
          push(1'b1);
        end else begin
          stall++;
        end
      end else begin
        stall = 0;
      end
`endif
    end
  endtask

  task automatic send(input byte unsigned b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    model_edge(1'b1, b);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge(1'b0, 8'h00);
      #1;
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_sw_model"}, 32'(switch_data), 32'(m_sw));
    check({tag, "_bt_model"}, 32'(button_data), 32'(m_bt));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (reset_n === 1'b1) begin
        if (cmd_done || cmd_error) begin
          check("pulse_overlap", 32'(cmd_done & cmd_error), 32'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: done=%0b error=%0b, expected no pulse", cmd_done, cmd_error);
          end else begin
            mon_x = exp_q.pop_front();
            check("pulse_kind_error", 32'(cmd_error), 32'(mon_x.is_err));
            check("pulse_cycle", 32'(neg_cnt), 32'(mon_x.when));
            check("pulse_switch_data", 32'(switch_data), 32'(mon_x.sw));
            check("pulse_button_data", 32'(button_data), 32'(mon_x.bt));
          end
        end else if (exp_q.size() > 0 && exp_q[0].when < neg_cnt) begin
          mon_x = exp_q.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missing_pulse: no pulse seen, expected %s by cycle %0d",
                   mon_x.is_err ? "cmd_error" : "cmd_done", mon_x.when);
        end
      end
    end
  end

  initial begin
    byte unsigned cq[$];
    int nd, k;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_switch", 32'(switch_data), 32'd0);
    check("reset_button", 32'(button_data), 32'd0);
    check("reset_done", 32'(cmd_done), 32'd0);
    check("reset_error", 32'(cmd_error), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    send_str("SW: 0xFFFF\r");
    idle(2);
    check("t1_sw", 32'(switch_data), 32'hFFFF);
    check("t1_bt", 32'(button_data), 32'h0);

    send_str("BT:0x1b\n");
    idle(1);
    check("t2a_bt", 32'(button_data), 32'h1B);
    send_str("BT:   0XFF\r");
    idle(1);
    check("t2b_bt_trunc", 32'(button_data), 32'h1F);
    check("t2_sw", 32'(switch_data), 32'hFFFF);

    send_str("SW: 0x12345\r");
    idle(1);
    check("t3_sw_overflow", 32'(switch_data), 32'hFFFF);
    send_str("ABCDEFGHIJ");
    idle(2);
    check_out("t3");

    send_str("SW: 0x12");
    reset_n = 1'b0;
    #1;
    check("t4_rst_sw", 32'(switch_data), 32'd0);
    check("t4_rst_bt", 32'(button_data), 32'd0);
    in_cmd = 0;
    cbuf.delete();
    m_sw = '0;
    m_bt = '0;
    stall = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_str("34\r");
    idle(2);
    check("t4_after_sw", 32'(switch_data), 32'd0);

    send_str("SW: 0xA");
    ena = 1'b0;
    send(8'h35);
    send(8'h0D);
    idle(18);
    ena = 1'b1;
    send_str("5\r");
    idle(1);
    check("t5_ena_sw", 32'(switch_data), 32'h00A5);

    send_str("BT: 0x1");
    idle(16);
    send(8'h0D);
    idle(2);
`ifdef CMD_TIMEOUT_EN
    check("t6_timeout_bt", 32'(button_data), 32'h0);
`else
    check("t6_no_timeout_bt", 32'(button_data), 32'h1);
`endif

    for (int c = 0; c < 200; c++) begin
      cq.delete();
      if ($urandom % 4 == 0) send(8'($urandom_range(0, 255)));
      if ($urandom % 2 == 0) begin cq.push_back("S"); cq.push_back("W"); end
      else begin cq.push_back("B"); cq.push_back("T"); end
      cq.push_back(":");
      repeat ($urandom_range(0, 3)) cq.push_back(" ");
      cq.push_back("0");
      cq.push_back(($urandom % 2 == 0) ? 8'h78 : 8'h58);
      nd = ($urandom % 8 == 0) ? 5 : int'($urandom_range(1, 4));
      repeat (nd) begin
        k = int'($urandom % 16);
        if (k < 10) cq.push_back(8'(48 + k));
        else if ($urandom % 2 == 0) cq.push_back(8'(55 + k));
        else cq.push_back(8'(87 + k));
      end
      cq.push_back(($urandom % 2 == 0) ? 8'h0D : 8'h0A);
      if ($urandom % 5 == 0) cq[$urandom_range(1, cq.size() - 1)] = 8'($urandom_range(0, 255));
      foreach (cq[i]) begin
        if ($urandom % 6 == 0) idle($urandom_range(1, 3));
        if ($urandom % 10 == 0) begin
          ena = 1'b0;
          repeat ($urandom_range(1, 4)) send(8'($urandom_range(0, 255)));
          ena = 1'b1;
        end
        send(cq[i]);
      end
    end

    idle(5);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    check_out("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
